sseg_scan_capture: RTL and testbench
====================================

# sseg_scan_capture

Receive-side counterpart of the four-digit seven-segment scan multiplexer. It samples a time-multiplexed anode/segment bus (`an`, `sseg`) and demultiplexes it back into four per-digit segment bytes. It publishes a coherent snapshot once every digit has been seen in a scan. The block sits behind the display pins for board self-check and for forwarding display contents to a host, and it is used in benches as the display monitor.

## Interface
- `STABLE_CYCLES`, default 16: consecutive unchanged cycles of `{an,sseg}` required before a digit is accepted; legal range 2..65535.
- `CNT_W`, default 16: stability counter width; must satisfy 2^CNT_W > STABLE_CYCLES.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `an`  in  4  anode enables, active-low; exactly one zero selects a digit, bit i = digit i.
- `sseg`  in  8  segment byte for the selected digit; passed through opaquely.
- `disp3`..`disp0`  out  8 each  last complete frame, one byte per digit.
- `frame_valid`  out  1  one-cycle pulse when `disp*` updates.
- `an_err`  out  1  one-cycle pulse when a stable `an` has more than one zero.

## Operation
- Input stage: `an` and `sseg` are registered once into `an_q`/`sseg_q`. All logic below uses the registered copies.
- Stability counter `stab_cnt`:
  - Clears to 0 on any cycle where `{an_q,sseg_q}` differs from its previous value.
  - Otherwise increments, saturating at STABLE_CYCLES.
- FSM has three states:
  - SETTLE: counting. On `stab_cnt == STABLE_CYCLES-1` with no change, act on `an_q` and go to HELD.
  - HELD: the dwell has already been acted on. Any change returns to SETTLE. No further capture occurs for this dwell, however long it lasts.
  - Reset state is SETTLE.
- Actions at the accept point, selected by `an_q`:
  - Exactly one zero at index i: `dig[i] <= sseg_q` and `seen[i] <= 1`.
  - 4'b1111 (blanking): ignored, no error.
  - Two or more zeros: `an_err` pulses; no capture; `seen` is unchanged.
- Frame completion: when a capture makes `seen == 4'b1111`:
  - `disp0..disp3` load `dig` in that same cycle; the just-captured byte is included.
  - `frame_valid` pulses.
  - `seen` clears to 4'b0000.
- Repeated digits: recapturing a digit already in `seen` overwrites `dig[i]`; the newest value wins. Digit order is irrelevant.
- Reset values:
  - `disp*` = 8'hFF (all segments off, active-low).
  - `frame_valid` = 0, `an_err` = 0.
  - `seen` = 0, `dig` = 8'hFF, `stab_cnt` = 0, `an_q` = 4'hF, `sseg_q` = 8'hFF.
- Reset mid-dwell discards partial frame state. The first frame after reset requires all four digits anew.

## Timing
- Accept latency: a value presented on the pins at cycle t, held steady, is captured at the edge ending cycle t+STABLE_CYCLES. This is 1 cycle of input register plus STABLE_CYCLES-1 of counting.
- `frame_valid` and the `disp*` update occur at the same edge as the completing capture.
- A glitch of one cycle restarts the count. A dwell shorter than STABLE_CYCLES+1 pin cycles is never captured.
- A change arriving on the exact accept cycle cancels the accept: the change takes priority.
- `an_err` and `frame_valid` are never asserted in the same cycle.

## Configuration
- `SSEG_CAPTURE_DECODE_EN` defined:
  - Adds outputs `hex3`..`hex0` (4 bits each, decoded from `disp*`) and `dec_err` (4 bits, bit i set when `disp_i[6:0]` matches no hex glyph).
  - Decoded values are registered and update in the cycle after `frame_valid`.
  - Encoding: `sseg[7]` = dp, `sseg[6:0]` = {g,f,e,d,c,b,a}, active-low, standard 0–F glyphs.
  - Reset values: `hex*` = 0, `dec_err` = 0.
- Undefined: these ports and the decode logic are absent.

## Structure
- Shared package `sseg_pkg`:
  - The 16 active-low glyph constants `SSEG_GLYPH_0`..`SSEG_GLYPH_F`.
  - The blank constant `SSEG_BLANK = 8'hFF`.
  - The FSM state typedef.
- One sub-module, `sseg_to_hex`: combinational 7-bit pattern to {valid, nibble}. It is instantiated four times under `SSEG_CAPTURE_DECODE_EN`.

## Test plan
- Clean scan, STABLE_CYCLES=16: present `an`=1110/1101/1011/0111 for 100 cycles each with `sseg` = 8'hC0/8'hF9/8'hA4/8'hB0 respectively.
  - Expect `frame_valid` once, at the 0111 dwell.
  - Expect `disp0..3` = C0, F9, A4, B0.
  - With decode enabled, expect `hex` = 0, 1, 2, 3 and `dec_err` = 0.
- Short dwell: hold `an`=1101 for 16 pin cycles, then go to 1111.
  - Expect no capture of digit 1 and no `frame_valid`.
  - Repeat with 17 pin cycles: expect digit 1 captured.
- Glitch: insert a one-cycle `sseg` flip at cycle 10 of a 100-cycle dwell.
  - Expect capture 16 cycles after the glitch ends, exactly once.
- Bad anodes: hold `an`=1100 for 50 cycles.
  - Expect exactly one `an_err` pulse, no change in `seen`, no `frame_valid`.
- Repeated digit: scan 0, 0 (new value 8'h80), 1, 2, 3.
  - Expect a single `frame_valid` with `disp0`=8'h80.
- Reset mid-frame: after capturing digits 0 and 1, assert `reset` for 1 cycle.
  - Expect `disp*`=FF immediately.
  - Then scan digits 2 and 3 only: expect no `frame_valid`.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions: active-low glyphs ({dp,g,f,e,d,c,b,a}),
// the capture FSM state type and anode-select helpers.
package sseg_pkg;

  localparam logic [7:0] SSEG_GLYPH_0 = 8'hC0;
  localparam logic [7:0] SSEG_GLYPH_1 = 8'hF9;
  localparam logic [7:0] SSEG_GLYPH_2 = 8'hA4;
  localparam logic [7:0] SSEG_GLYPH_3 = 8'hB0;
  localparam logic [7:0] SSEG_GLYPH_4 = 8'h99;
  localparam logic [7:0] SSEG_GLYPH_5 = 8'h92;
  localparam logic [7:0] SSEG_GLYPH_6 = 8'h82;
  localparam logic [7:0] SSEG_GLYPH_7 = 8'hF8;
  localparam logic [7:0] SSEG_GLYPH_8 = 8'h80;
  localparam logic [7:0] SSEG_GLYPH_9 = 8'h90;
  localparam logic [7:0] SSEG_GLYPH_A = 8'h88;
  localparam logic [7:0] SSEG_GLYPH_B = 8'h83;
  localparam logic [7:0] SSEG_GLYPH_C = 8'hC6;
  localparam logic [7:0] SSEG_GLYPH_D = 8'hA1;
  localparam logic [7:0] SSEG_GLYPH_E = 8'h86;
  localparam logic [7:0] SSEG_GLYPH_F = 8'h8E;
  localparam logic [7:0] SSEG_BLANK   = 8'hFF;

  localparam int unsigned NUM_DIGITS = 4;

  // SETTLE: waiting for the bus to sit still; HELD: this dwell is already consumed.
  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_HELD   = 1'b1
  } cap_state_t;

  // {hit, index}: hit is set only when exactly one anode is driven low.
  function automatic logic [2:0] an_select(input logic [3:0] an);
    case (an)
      4'b1110: return {1'b1, 2'd0};
      4'b1101: return {1'b1, 2'd1};
      4'b1011: return {1'b1, 2'd2};
      4'b0111: return {1'b1, 2'd3};
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic an_is_blank(input logic [3:0] an);
    return an == 4'b1111;
  endfunction

endpackage

// File: rtl/sseg_to_hex.sv
// Combinational inverse of the hex glyph table: 7-bit segment pattern to
// {valid, nibble}; unknown patterns report valid = 0 and nibble = 0.
module sseg_to_hex
  import sseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] nibble
);

  always_comb begin
    valid  = 1'b1;
    nibble = 4'h0;
    case (seg)
      SSEG_GLYPH_0[6:0]: nibble = 4'h0;
      SSEG_GLYPH_1[6:0]: nibble = 4'h1;
      SSEG_GLYPH_2[6:0]: nibble = 4'h2;
      SSEG_GLYPH_3[6:0]: nibble = 4'h3;
      SSEG_GLYPH_4[6:0]: nibble = 4'h4;
      SSEG_GLYPH_5[6:0]: nibble = 4'h5;
      SSEG_GLYPH_6[6:0]: nibble = 4'h6;
      SSEG_GLYPH_7[6:0]: nibble = 4'h7;
      SSEG_GLYPH_8[6:0]: nibble = 4'h8;
      SSEG_GLYPH_9[6:0]: nibble = 4'h9;
      SSEG_GLYPH_A[6:0]: nibble = 4'hA;
      SSEG_GLYPH_B[6:0]: nibble = 4'hB;
      SSEG_GLYPH_C[6:0]: nibble = 4'hC;
      SSEG_GLYPH_D[6:0]: nibble = 4'hD;
      SSEG_GLYPH_E[6:0]: nibble = 4'hE;
      SSEG_GLYPH_F[6:0]: nibble = 4'hF;
      default: begin
        valid  = 1'b0;
        nibble = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/sseg_scan_capture.sv
// Demultiplexes a scanned four-digit anode/segment bus into per-digit bytes and
// publishes a coherent frame once all digits are seen. Define SSEG_CAPTURE_DECODE_EN
// to add registered hex decode outputs (hex3..hex0, dec_err).
module sseg_scan_capture
  import sseg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an,
  input  logic [7:0] sseg,
  output logic [7:0] disp3,
  output logic [7:0] disp2,
  output logic [7:0] disp1,
  output logic [7:0] disp0,
  output logic       frame_valid,
`ifdef SSEG_CAPTURE_DECODE_EN
  output logic [3:0] hex3,
  output logic [3:0] hex2,
  output logic [3:0] hex1,
  output logic [3:0] hex0,
  output logic [3:0] dec_err,
`endif
  output logic       an_err
);

  localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(STABLE_CYCLES);

  logic [3:0]       an_q;
  logic [7:0]       sseg_q;
  logic [CNT_W-1:0] stab_cnt;
  cap_state_t       state;
  logic [7:0]       dig [NUM_DIGITS];
  logic [3:0]       seen;

  logic       change;
  logic       accept;
  logic [2:0] sel;
  logic       hit;
  logic [1:0] idx;
  logic       multi;
  logic [3:0] seen_cap;
  logic       complete;

  // A change is judged as the input register loads, so the counter tracks the
  // age of the registered copy and a change on the accept cycle wins.
  always_comb begin
    change   = {an, sseg} != {an_q, sseg_q};
    accept   = (state == ST_SETTLE) && !change && (stab_cnt == CNT_ACCEPT);
    sel      = an_select(an_q);
    hit      = sel[2];
    idx      = sel[1:0];
    multi    = !hit && !an_is_blank(an_q);
    seen_cap = seen | (4'b0001 << idx);
    complete = seen_cap == 4'b1111;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q        <= 4'hF;
      sseg_q      <= SSEG_BLANK;
      stab_cnt    <= '0;
      state       <= ST_SETTLE;
      seen        <= 4'b0000;
      for (int i = 0; i < NUM_DIGITS; i++) dig[i] <= SSEG_BLANK;
      disp0       <= SSEG_BLANK;
      disp1       <= SSEG_BLANK;
      disp2       <= SSEG_BLANK;
      disp3       <= SSEG_BLANK;
      frame_valid <= 1'b0;
      an_err      <= 1'b0;
    end else begin
      an_q        <= an;
      sseg_q      <= sseg;
      frame_valid <= 1'b0;
      an_err      <= 1'b0;
      if (change) begin
        stab_cnt <= '0;
        state    <= ST_SETTLE;
      end else begin
        if (stab_cnt != CNT_SAT) stab_cnt <= stab_cnt + CNT_W'(1);
        if (accept) begin
          state <= ST_HELD;
          if (hit) begin
            dig[idx] <= sseg_q;
            if (complete) begin
              // Frame publishes the just-captured byte in place of its stale copy.
              disp0       <= (idx == 2'd0) ? sseg_q : dig[0];
              disp1       <= (idx == 2'd1) ? sseg_q : dig[1];
              disp2       <= (idx == 2'd2) ? sseg_q : dig[2];
              disp3       <= (idx == 2'd3) ? sseg_q : dig[3];
              frame_valid <= 1'b1;
              seen        <= 4'b0000;
            end else begin
              seen <= seen_cap;
            end
          end else if (multi) begin
            an_err <= 1'b1;
          end
        end
      end
    end
  end

`ifdef SSEG_CAPTURE_DECODE_EN
  logic [6:0] disp_seg [NUM_DIGITS];
  logic [3:0] nib      [NUM_DIGITS];
  logic [3:0] ok;

  assign disp_seg[0] = disp0[6:0];
  assign disp_seg[1] = disp1[6:0];
  assign disp_seg[2] = disp2[6:0];
  assign disp_seg[3] = disp3[6:0];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    sseg_to_hex u_dec (
      .seg    (disp_seg[g]),
      .valid  (ok[g]),
      .nibble (nib[g])
    );
  end

  // disp* is already updated while frame_valid is high, so decode follows one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex0    <= 4'h0;
      hex1    <= 4'h0;
      hex2    <= 4'h0;
      hex3    <= 4'h0;
      dec_err <= 4'h0;
    end else if (frame_valid) begin
      hex0    <= nib[0];
      hex1    <= nib[1];
      hex2    <= nib[2];
      hex3    <= nib[3];
      dec_err <= ~ok;
    end
  end
`endif

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Scoreboard bench for sseg_scan_capture: stimulus pushes expected frames,
// a monitor pops and compares on every frame_valid pulse.
module tb_sseg_scan_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] an;
  logic [7:0] sseg;
  logic [7:0] disp3, disp2, disp1, disp0;
  logic       frame_valid;
  logic       an_err;
`ifdef SSEG_CAPTURE_DECODE_EN
  logic [3:0] hex3, hex2, hex1, hex0;
  logic [3:0] dec_err;
`endif

  sseg_scan_capture #(.STABLE_CYCLES(16), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .an          (an),
    .sseg        (sseg),
    .disp3       (disp3),
    .disp2       (disp2),
    .disp1       (disp1),
    .disp0       (disp0),
    .frame_valid (frame_valid),
`ifdef SSEG_CAPTURE_DECODE_EN
    .hex3        (hex3),
    .hex2        (hex2),
    .hex1        (hex1),
    .hex0        (hex0),
    .dec_err     (dec_err),
`endif
    .an_err      (an_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;     // {d3,d2,d1,d0}
    logic [15:0] hx;    // {h3,h2,h1,h0}
    logic [3:0]  derr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   frames = 0;
  int   an_errs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hold one bus value for n pin cycles; called and returns at a falling edge.
  task automatic dwell(input logic [3:0] a, input logic [7:0] s, input int n);
    an   = a;
    sseg = s;
    repeat (n) @(negedge clk);
  endtask

  function automatic exp_t mk(input logic [31:0] d, input logic [15:0] hx, input logic [3:0] derr);
    exp_t e;
    e.d    = d;
    e.hx   = hx;
    e.derr = derr;
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    exp_t last = '0;
    logic hex_pending = 1'b0;
    forever begin
      @(negedge clk);
`ifdef SSEG_CAPTURE_DECODE_EN
      if (hex_pending) begin
        logic [15:0] hx_act;
        hx_act = {hex3, hex2, hex1, hex0};
        check("dec_err", 32'(dec_err), 32'(last.derr));
        for (int i = 0; i < 4; i++)
          if (!last.derr[i]) check($sformatf("hex%0d", i), 32'(hx_act[i*4 +: 4]), 32'(last.hx[i*4 +: 4]));
      end
`endif
      hex_pending = 1'b0;
      if (frame_valid && an_err) check("fv_and_an_err", 32'(1), 32'(0));
      if (an_err) an_errs++;
      if (frame_valid) begin
        frames++;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'(frame_valid), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("disp0", 32'(disp0), 32'(e.d[7:0]));
          check("disp1", 32'(disp1), 32'(e.d[15:8]));
          check("disp2", 32'(disp2), 32'(e.d[23:16]));
          check("disp3", 32'(disp3), 32'(e.d[31:24]));
          last = e;
          hex_pending = 1'b1;
        end
      end
    end
  endtask

  initial begin
    an    = 4'hF;
    sseg  = 8'hFF;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_disp", {disp3, disp2, disp1, disp0}, 32'hFFFF_FFFF);
    check("reset_fv", 32'(frame_valid), 32'(0));
    check("reset_an_err", 32'(an_err), 32'(0));
`ifdef SSEG_CAPTURE_DECODE_EN
    check("reset_hex", 32'({hex3, hex2, hex1, hex0}), 32'(0));
    check("reset_dec_err", 32'(dec_err), 32'(0));
`endif
    reset = 1'b0;
    fork
      monitor();
    join_none

    // Clean scan
    exp_q.push_back(mk(32'hB0A4_F9C0, 16'h3210, 4'h0));
    dwell(4'b1110, 8'hC0, 100);
    dwell(4'b1101, 8'hF9, 100);
    dwell(4'b1011, 8'hA4, 100);
    dwell(4'b0111, 8'hB0, 100);
    dwell(4'b1111, 8'hFF, 20);

    // Short dwell of 16 is dropped; 17 completes the frame
    dwell(4'b1101, 8'h92, 16);
    dwell(4'b1111, 8'hFF, 30);
    dwell(4'b1110, 8'hC6, 40);
    dwell(4'b1011, 8'hA1, 40);
    dwell(4'b0111, 8'h7F, 40);
    dwell(4'b1111, 8'hFF, 30);
    check("short_dwell_no_frame", 32'(frames), 32'(1));
    exp_q.push_back(mk(32'h7FA1_92C6, 16'h0D5C, 4'b1000));
    dwell(4'b1101, 8'h92, 17);
    dwell(4'b1111, 8'hFF, 30);

    // One-cycle glitch inside a digit-0 dwell
    exp_q.push_back(mk(32'h80F8_8388, 16'h87BA, 4'h0));
    dwell(4'b1110, 8'h88, 10);
    dwell(4'b1110, 8'h89, 1);
    dwell(4'b1110, 8'h88, 89);
    dwell(4'b1101, 8'h83, 40);
    dwell(4'b1011, 8'hF8, 40);
    dwell(4'b0111, 8'h80, 40);
    dwell(4'b1111, 8'hFF, 20);

    // Bad anodes: a single error pulse, seen untouched
    dwell(4'b1100, 8'hA4, 50);
    dwell(4'b1111, 8'hFF, 20);
    check("an_err_count", 32'(an_errs), 32'(1));
    check("bad_an_no_frame", 32'(frames), 32'(3));

    // Repeated digit 0: newest value wins
    exp_q.push_back(mk(32'hB0A4_F980, 16'h3218, 4'h0));
    dwell(4'b1110, 8'hC0, 40);
    dwell(4'b1110, 8'h80, 40);
    dwell(4'b1101, 8'hF9, 40);
    dwell(4'b1011, 8'hA4, 40);
    dwell(4'b0111, 8'hB0, 40);
    dwell(4'b1111, 8'hFF, 20);

    // Reset mid-frame discards digits 0 and 1
    dwell(4'b1110, 8'hC0, 40);
    dwell(4'b1101, 8'hF9, 40);
    an    = 4'hF;
    sseg  = 8'hFF;
    reset = 1'b1;
    @(negedge clk);
    check("midreset_disp", {disp3, disp2, disp1, disp0}, 32'hFFFF_FFFF);
    reset = 1'b0;
    dwell(4'b1111, 8'hFF, 5);
    dwell(4'b1011, 8'hA4, 40);
    dwell(4'b0111, 8'hB0, 40);
    dwell(4'b1111, 8'hFF, 40);

    check("frames_total", 32'(frames), 32'(4));
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    check("an_err_final", 32'(an_errs), 32'(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
